// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared types and saturating add for the CiM partial-sum accumulator
package cim_pkg;

  localparam int Q_WIDTH   = 22;
  localparam int ACC_WIDTH = 32;
  localparam int CNT_WIDTH = 8;

  typedef enum logic {IDLE, ACCUM} psum_state_t;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] data;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sat;
  } psum_res_t;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] value;
    logic                 clamped;
  } sat_sum_t;

  // One extra bit of headroom; the top two bits disagree exactly when the true sum is out of range.
  function automatic sat_sum_t sat_add_acc(input logic [ACC_WIDTH-1:0] a,
                                           input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] sum;
    sat_sum_t r;
    sum = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    r.clamped = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    if (!r.clamped)
      r.value = sum[ACC_WIDTH-1:0];
    else if (sum[ACC_WIDTH])
      r.value = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      r.value = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/cim_psum_fifo.sv
// rtl/cim_psum_fifo.sv - sync FIFO of group results with registered head and full+pop bypass
module cim_psum_fifo
  import cim_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      PUSH,
  input  psum_res_t PUSH_DATA,
  output logic      FULL,
  input  logic      POP,
  output logic      EMPTY,
  output psum_res_t HEAD
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  psum_res_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [PTR_W:0]   count, count_n;
  logic             do_push, do_pop;
  psum_res_t        head_n;

  assign FULL    = (count == FULL_CNT);
  assign EMPTY   = (count == '0);
  assign do_pop  = POP & ~EMPTY;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = PUSH & (~FULL | do_pop);

  assign rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;
  assign count_n  = count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};

  always_comb begin
    head_n = mem[rd_ptr_n];
    if (do_push && (wr_ptr == rd_ptr_n))
      head_n = PUSH_DATA;
    if (count_n == '0)
      head_n = '0;
  end

  always_ff @(posedge CLK) begin
    if (do_push)
      mem[wr_ptr] <= PUSH_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      HEAD   <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      HEAD   <= head_n;
    end
  end

endmodule

// File: rtl/cim_psum_accumulator.sv
// rtl/cim_psum_accumulator.sv - saturating FIRST/LAST-framed partial-sum accumulator with result FIFO
// Optional CIM_PSUM_RELU_EN: pushed result is max(acc,0).
module cim_psum_accumulator #(
  parameter int Q_WIDTH    = cim_pkg::Q_WIDTH,
  parameter int ACC_WIDTH  = cim_pkg::ACC_WIDTH,
  parameter int CNT_WIDTH  = cim_pkg::CNT_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [Q_WIDTH-1:0]   Q_IN,
  input  logic                 Q_VALID,
  input  logic                 Q_FIRST,
  input  logic                 Q_LAST,
  output logic [ACC_WIDTH-1:0] RES_DATA,
  output logic [CNT_WIDTH-1:0] RES_CNT,
  output logic                 RES_SAT,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  input  logic                 ERR_CLR,
  output logic                 ERR_OVF,
  output logic                 ERR_PROTO,
  output logic                 BUSY
);

  import cim_pkg::*;

  psum_state_t          state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 sat_q, sat_d;
  logic                 err_ovf_q, err_proto_q;
  logic [ACC_WIDTH-1:0] q_ext;
  sat_sum_t             sum;
  logic                 push, pop, proto_err, ovf;
  logic                 fifo_full, fifo_empty;
  psum_res_t            push_res, head;

  function automatic logic [ACC_WIDTH-1:0] push_value(input logic [ACC_WIDTH-1:0] v);
`ifdef CIM_PSUM_RELU_EN
    return v[ACC_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign q_ext   = {{(ACC_WIDTH-Q_WIDTH){Q_IN[Q_WIDTH-1]}}, Q_IN};
  assign sum     = sat_add_acc(acc_q, q_ext);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    push      = 1'b0;
    push_res  = '0;
    proto_err = 1'b0;
    if (Q_VALID) begin
      if (Q_FIRST) begin
        // FIRST inside an open group abandons it and restarts from this term.
        proto_err = (state_q == ACCUM);
        acc_d     = q_ext;
        cnt_d     = CNT_WIDTH'(1);
        sat_d     = 1'b0;
        if (Q_LAST) begin
          push     = 1'b1;
          push_res = '{data: push_value(q_ext), cnt: CNT_WIDTH'(1), sat: 1'b0};
          state_d  = IDLE;
        end else begin
          state_d  = ACCUM;
        end
      end else if (state_q == IDLE) begin
        proto_err = 1'b1;
      end else begin
        acc_d = sum.value;
        cnt_d = cnt_inc;
        sat_d = sat_q | sum.clamped;
        if (Q_LAST) begin
          push     = 1'b1;
          push_res = '{data: push_value(sum.value), cnt: cnt_inc, sat: sat_d};
          state_d  = IDLE;
        end
      end
    end
  end

  assign pop = RES_VALID & RES_READY;
  assign ovf = push & fifo_full & ~pop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      err_ovf_q   <= ovf | (err_ovf_q & ~ERR_CLR);
      err_proto_q <= proto_err | (err_proto_q & ~ERR_CLR);
    end
  end

  cim_psum_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .PUSH     (push),
    .PUSH_DATA(push_res),
    .FULL     (fifo_full),
    .POP      (pop),
    .EMPTY    (fifo_empty),
    .HEAD     (head)
  );

  assign RES_DATA  = head.data;
  assign RES_CNT   = head.cnt;
  assign RES_SAT   = head.sat;
  assign RES_VALID = ~fifo_empty;
  assign ERR_OVF   = err_ovf_q;
  assign ERR_PROTO = err_proto_q;
  assign BUSY      = (state_q == ACCUM);

endmodule

// File: tb/tb_cim_psum_accumulator.sv
// tb/tb_cim_psum_accumulator.sv - directed table-driven bench for cim_psum_accumulator
module tb_cim_psum_accumulator;

  logic        CLK = 1'b0;
  logic        RST;
  logic [21:0] Q_IN;
  logic        Q_VALID, Q_FIRST, Q_LAST;
  logic [31:0] RES_DATA;
  logic [7:0]  RES_CNT;
  logic        RES_SAT, RES_VALID, RES_READY, ERR_CLR, ERR_OVF, ERR_PROTO, BUSY;

  cim_psum_accumulator dut (
    .CLK(CLK), .RST(RST), .Q_IN(Q_IN), .Q_VALID(Q_VALID), .Q_FIRST(Q_FIRST),
    .Q_LAST(Q_LAST), .RES_DATA(RES_DATA), .RES_CNT(RES_CNT), .RES_SAT(RES_SAT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .ERR_CLR(ERR_CLR),
    .ERR_OVF(ERR_OVF), .ERR_PROTO(ERR_PROTO), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v, f, l;
    logic [21:0] q;
    logic        rdy, clr;
    logic        e_rv;
    logic [31:0] e_data;
    logic [7:0]  e_cnt;
    logic        e_sat, e_proto, e_busy;
  } vec_t;

  vec_t tbl[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic int relu(input int v);
`ifdef CIM_PSUM_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic vec_t mk(input logic v, f, l, input int q, input logic rdy, clr,
                              input logic e_rv, input int e_data, input int e_cnt,
                              input logic e_sat, e_proto, e_busy);
    vec_t r;
    r.v = v; r.f = f; r.l = l; r.q = 22'(q); r.rdy = rdy; r.clr = clr;
    r.e_rv = e_rv; r.e_data = 32'(e_data); r.e_cnt = 8'(e_cnt);
    r.e_sat = e_sat; r.e_proto = e_proto; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic v, f, l, input int q);
    Q_VALID = v; Q_FIRST = f; Q_LAST = l; Q_IN = 22'(q);
  endtask

  task automatic single(input int q);
    drive(1'b1, 1'b1, 1'b1, q);
    step();
    drive(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk_head(input string name, input int data, input int cnt, input logic sat);
    chk({name, "_valid"}, 32'(RES_VALID), 32'd1);
    chk({name, "_data"}, RES_DATA, 32'(data));
    chk({name, "_cnt"}, 32'(RES_CNT), 32'(cnt));
    chk({name, "_sat"}, 32'(RES_SAT), 32'(sat));
  endtask

  initial begin
    RST = 1'b1; RES_READY = 1'b0; ERR_CLR = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0);
    step(); step();
    RST = 1'b0;
    chk("rst_valid", 32'(RES_VALID), 32'd0);
    chk("rst_data", RES_DATA, 32'd0);
    chk("rst_cnt", 32'(RES_CNT), 32'd0);
    chk("rst_sat", 32'(RES_SAT), 32'd0);
    chk("rst_ovf", 32'(ERR_OVF), 32'd0);
    chk("rst_proto", 32'(ERR_PROTO), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);

    //             v  f  l   q    rdy clr  rv  data        cnt sat pro busy
    tbl.push_back(mk(1, 1, 0, 100, 0, 0,   0, 0,          0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, -30, 0, 0,   0, 0,          0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 7,   0, 0,   0, 0,          0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, -2,  0, 0,   1, 75,         4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   1, 0,   0, 0,          0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, -5,  0, 0,   1, relu(-5),   1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0,   1, relu(-5),   1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   1, 0,   0, 0,          0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 3,   0, 0,   0, 0,          0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 1,   0, 0,          0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 10,  0, 0,   0, 0,          0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 20,  0, 0,   0, 0,          0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 1, 3,   0, 0,   1, 23,         2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,   1, 1,   0, 0,          0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].l, int'($signed(tbl[i].q)));
      RES_READY = tbl[i].rdy; ERR_CLR = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(RES_VALID), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        chk($sformatf("vec%0d_data", i), RES_DATA, tbl[i].e_data);
        chk($sformatf("vec%0d_cnt", i), 32'(RES_CNT), 32'(tbl[i].e_cnt));
        chk($sformatf("vec%0d_sat", i), 32'(RES_SAT), 32'(tbl[i].e_sat));
      end
      chk($sformatf("vec%0d_proto", i), 32'(ERR_PROTO), 32'(tbl[i].e_proto));
      chk($sformatf("vec%0d_busy", i), 32'(BUSY), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_ovf", i), 32'(ERR_OVF), 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 0); RES_READY = 1'b0; ERR_CLR = 1'b0;
    step();

    // 1025 max-positive terms: saturates, count pins at 255
    for (int i = 0; i < 1025; i++) begin
      drive(1'b1, i == 0, i == 1024, 2097151);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 0);
    chk_head("sat", 32'h7fffffff, 255, 1'b1);
    chk("sat_busy", 32'(BUSY), 32'd0);
    RES_READY = 1'b1; step(); RES_READY = 1'b0;
    chk("sat_drained", 32'(RES_VALID), 32'd0);

    // overflow: five results into a four-deep FIFO
    for (int k = 1; k <= 5; k++) single(k);
    chk("ovf_flag", 32'(ERR_OVF), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk_head($sformatf("ovf_head%0d", k), k, 1, 1'b0);
      RES_READY = 1'b1; step(); RES_READY = 1'b0;
    end
    chk("ovf_empty", 32'(RES_VALID), 32'd0);
    chk("ovf_sticky", 32'(ERR_OVF), 32'd1);
    ERR_CLR = 1'b1; step(); ERR_CLR = 1'b0;
    chk("ovf_clr", 32'(ERR_OVF), 32'd0);

    // full FIFO with a pop in the same cycle as the push
    for (int k = 1; k <= 4; k++) single(k);
    RES_READY = 1'b1;
    single(9);
    RES_READY = 1'b0;
    chk("bypass_ovf", 32'(ERR_OVF), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("bypass_head%0d", k), (k == 3) ? 9 : k + 2, 1, 1'b0);
      RES_READY = 1'b1; step(); RES_READY = 1'b0;
    end
    chk("bypass_empty", 32'(RES_VALID), 32'd0);

    // reset mid-group discards the FIFO entry and the open group
    single(7);
    drive(1'b1, 1'b1, 1'b0, 50); step();
    chk("mid_busy", 32'(BUSY), 32'd1);
    RST = 1'b1; drive(1'b1, 1'b0, 1'b1, 1); step();
    RST = 1'b0; drive(1'b0, 1'b0, 1'b0, 0);
    chk("mrst_valid", 32'(RES_VALID), 32'd0);
    chk("mrst_data", RES_DATA, 32'd0);
    chk("mrst_cnt", 32'(RES_CNT), 32'd0);
    chk("mrst_busy", 32'(BUSY), 32'd0);
    chk("mrst_proto", 32'(ERR_PROTO), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1); step(); drive(1'b0, 1'b0, 1'b0, 0);
    chk("mrst_after_valid", 32'(RES_VALID), 32'd0);
    chk("mrst_after_proto", 32'(ERR_PROTO), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cim_psum_accumulator.md
Name: cim_psum_accumulator

Overview:
- Downstream of the 16-core CiM macro. Consumes its 22-bit signed adder-tree result Q, one value per valid cycle.
- Accumulates consecutive partial sums (one per weight row or tile) into a wide saturating accumulator, delimited by FIRST/LAST markers.
- Pushes each finished group result into a small output FIFO drained by a valid/ready consumer.
- The macro pipeline cannot stall, so the input side has no backpressure; overflow and protocol errors are flagged sticky.

Parameters:
- Q_WIDTH, 22, input partial-sum width, signed two's complement
- ACC_WIDTH, 32, accumulator and result width, signed; must be > Q_WIDTH
- CNT_WIDTH, 8, term-counter width
- FIFO_DEPTH, 4, output FIFO entries, power of 2, >= 2

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- Q_IN  in  Q_WIDTH  signed partial sum from the macro
- Q_VALID  in  1  Q_IN valid this cycle
- Q_FIRST  in  1  first term of a group; qualified by Q_VALID
- Q_LAST  in  1  last term of a group; qualified by Q_VALID
- RES_DATA  out  ACC_WIDTH  FIFO head: group result
- RES_CNT  out  CNT_WIDTH  FIFO head: number of terms in the group (saturating)
- RES_SAT  out  1  FIFO head: saturation occurred in the group
- RES_VALID  out  1  FIFO non-empty
- RES_READY  in  1  consumer accepts the head
- ERR_CLR  in  1  clears sticky error flags
- ERR_OVF  out  1  sticky: a result was dropped because the FIFO was full
- ERR_PROTO  out  1  sticky: FIRST/LAST framing violation
- BUSY  out  1  state == ACCUM

Behaviour:
- Clock and reset: one clock CLK. Reset is synchronous, active-high, on RST.
- Reset values: state IDLE; acc 0; cnt 0; sat 0; FIFO empty; RES_VALID 0; RES_DATA/RES_CNT/RES_SAT 0; ERR_OVF 0; ERR_PROTO 0; BUSY 0.
- Reset mid-group discards the group and the FIFO contents.
- State IDLE, event Q_VALID&Q_FIRST&!Q_LAST: acc=sext(Q_IN), cnt=1, sat=0, go to ACCUM.
- State IDLE, event Q_VALID&Q_FIRST&Q_LAST: single-term group. Push {sext(Q_IN),1,0}; stay IDLE.
- State IDLE, event Q_VALID&!Q_FIRST: term ignored; ERR_PROTO<=1.
- State ACCUM, event Q_VALID&!Q_FIRST: acc=sat_add(acc,sext(Q_IN)); cnt=min(cnt+1, 2^CNT_WIDTH-1). If Q_LAST, push the updated values and go to IDLE.
- State ACCUM, event Q_VALID&Q_FIRST: the open group is discarded and ERR_PROTO<=1. The new term then starts a group exactly as in IDLE (including the FIRST&LAST single-term case).
- Cycles with Q_VALID=0 hold all state; there is no timeout.
- Saturating add: compute an (ACC_WIDTH+1)-bit sum and clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets the group's sat bit, which stays set until the group ends.
- Latency: result pushed at the Q_LAST edge; RES_VALID=1 on the next cycle when the FIFO was empty.
- FIFO: registered outputs show the head entry. A pop happens when RES_VALID&RES_READY.
- FIFO, simultaneous push and pop when full: the push is accepted and the pop frees the slot.
- FIFO, push when full with no pop: the entry is dropped and ERR_OVF<=1.
- FIFO, RES_READY while empty: no effect.
- RES_DATA/RES_CNT/RES_SAT are stable while RES_VALID&!RES_READY.
- Error flags: ERR_CLR clears both flags. A new error in the same cycle as ERR_CLR wins (the flag stays 1).

Optional Feature:
- Macro: CIM_PSUM_RELU_EN.
- Defined: the pushed RES_DATA is max(acc,0), applied at push time; RES_SAT is unaffected.
- Undefined: the signed accumulator value is pushed unchanged.

Decomposition:
- Shared package cim_pkg holds:
  - localparams Q_WIDTH=22 and ACC_WIDTH=32
  - typedef enum logic {IDLE, ACCUM} psum_state_t
  - typedef struct packed psum_res_t {data, cnt, sat}
  - function sat_add_acc
- Sub-module cim_psum_fifo: parameterised sync FIFO of psum_res_t. It has push/full/pop/empty and a registered head; it implements full+pop bypass.

Test Plan:
- Group of 4 terms, Q_IN=100,-30,7,-2 with FIRST on term 1 and LAST on term 4 -> one cycle later RES_VALID=1, RES_DATA=75, RES_CNT=4, RES_SAT=0.
- Single term Q_IN=-5 with FIRST&LAST -> RES_DATA=-5 (0xFFFFFFFB) and RES_CNT=1; with CIM_PSUM_RELU_EN, RES_DATA=0.
- 1025 terms of Q_IN=2^21-1 (max positive), CNT_WIDTH=8 -> RES_DATA=2147483647, RES_SAT=1, RES_CNT=255.
- Hold RES_READY=0 and send 5 single-term groups (values 1..5) -> the FIFO holds 1..4 and ERR_OVF=1. Then assert RES_READY -> 1,2,3,4 drain in order. ERR_CLR -> ERR_OVF=0.
- FIFO full, RES_READY=1 in the same cycle as a LAST push of value 9 -> no ERR_OVF; 9 appears after the existing entries.
- Framing errors:
  - Q_VALID without FIRST in IDLE -> ignored, ERR_PROTO=1.
  - FIRST (10), then FIRST (20), then LAST (3) -> RES_DATA=23, RES_CNT=2, ERR_PROTO=1.
  - RST asserted mid-group -> no result, all outputs 0.
